// File: rtl/asi_reg_bridge.sv
// Bridge from wide ASI beats to a narrow register bus. Write beats are split into
// serial per-lane register writes; reads gather one or more lanes into one response beat.
module asi_reg_bridge #(
    parameter int AXI_SW = 3,
    parameter int AXI_AW = 32,
    parameter int AXI_DW = 128,
    parameter int REG_AW = 20,
    parameter int REG_DW = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [AXI_SW-1:0]       s_wsize,
    input  logic [AXI_AW-1:0]       s_waddr,
    input  logic [AXI_DW-1:0]       s_wdata,
    input  logic [AXI_DW/8-1:0]     s_wstrb,
    input  logic                    s_wlast,
    input  logic                    s_wvalid,
    output logic                    s_wready,
    output logic                    s_werr,
    output logic [AXI_SW-1:0]       m_wsize,
    output logic [REG_AW-$clog2(REG_DW/8)-1:0] m_waddr,
    output logic [REG_DW-1:0]       m_wdata,
    output logic [REG_DW/8-1:0]     m_wstrb,
    output logic                    m_wlast,
    output logic                    m_wvalid,
    input  logic                    m_wready,
    input  logic [AXI_SW-1:0]       s_rsize,
    input  logic [AXI_AW-1:0]       s_raddr,
    input  logic                    s_rvalid,
    output logic                    s_rready,
    output logic [AXI_DW-1:0]       s_rdata,
    output logic                    s_rslverr,
    output logic                    s_rdvalid,
    input  logic                    s_rdready,
    output logic [AXI_SW-1:0]       m_rsize,
    output logic [REG_AW-$clog2(REG_DW/8)-1:0] m_raddr,
    output logic                    m_rvalid,
    input  logic                    m_rready,
    input  logic [REG_DW-1:0]       m_rdata,
    input  logic                    m_rerr
);
    localparam int N_LANE = AXI_DW / REG_DW;
    localparam int MW     = (N_LANE > 1) ? $clog2(N_LANE) : 1;
    localparam int L      = $clog2(REG_DW / 8);
    localparam int SMAX   = $clog2(AXI_DW / 8);
    localparam int SB     = REG_DW / 8;
    localparam int WW     = REG_AW - L;
    localparam logic [WW-1:0] LANE_MASK = WW'(N_LANE - 1);

    localparam logic [0:0] W_IDLE  = 1'b0;
    localparam logic [0:0] W_ISSUE = 1'b1;
    localparam logic [1:0] R_IDLE  = 2'd0;
    localparam logic [1:0] R_REQ   = 2'd1;
    localparam logic [1:0] R_WAIT  = 2'd2;
    localparam logic [1:0] R_RESP  = 2'd3;

    function automatic logic [AXI_SW-1:0] reg_size(input logic [AXI_SW-1:0] sz);
        if (int'(sz) > L) begin
            return AXI_SW'(L);
        end else begin
            return sz;
        end
    endfunction

    logic [0:0]          wstate_r;
    logic [AXI_SW-1:0]   wsize_r;
    logic [WW-1:0]       waddr_r;
    logic [AXI_DW-1:0]   wdata_r;
    logic [AXI_DW/8-1:0] wstrb_r;
    logic                wlast_r;
    logic [N_LANE-1:0]   wmask_r;
    logic                werr_r;
    logic [N_LANE-1:0]   wmask_in_s;
    logic [N_LANE-1:0]   wrest_s;
    logic [MW-1:0]       wlane_s;
    logic                wbad_s;

    logic [1:0]          rstate_r;
    logic [AXI_SW-1:0]   rsize_r;
    logic [WW-1:0]       raddr_r;
    logic [MW-1:0]       rlane_r;
    logic [MW:0]         rcnt_r;
    logic [AXI_DW-1:0]   acc_r;
    logic                rerr_r;
    logic                rbad_s;
    int                  rn_s;
    logic [MW-1:0]       rstart_s;
    logic                unused_s;

    // Pending-lane mask of the incoming beat and the lowest pending lane of the latched one.
    always_comb begin
        wmask_in_s = {N_LANE{1'b0}};
        wlane_s    = {MW{1'b0}};
        for (int i = 0; i < N_LANE; i++) begin
            wmask_in_s[i] = |s_wstrb[i*SB +: SB];
        end
        for (int i = N_LANE - 1; i >= 0; i--) begin
            if (wmask_r[i]) begin
                wlane_s = MW'(i);
            end else begin
                wlane_s = wlane_s;
            end
        end
        wrest_s = wmask_r & ~(N_LANE'(1) << wlane_s);
        wbad_s  = int'(s_wsize) > SMAX;
    end

    // Write FSM: accept a beat, then issue one register write per pending lane.
    always_ff @(posedge clk) begin
        if (rst) begin
            wstate_r <= W_IDLE;
            wsize_r  <= {AXI_SW{1'b0}};
            waddr_r  <= {WW{1'b0}};
            wdata_r  <= {AXI_DW{1'b0}};
            wstrb_r  <= {(AXI_DW/8){1'b0}};
            wlast_r  <= 1'b0;
            wmask_r  <= {N_LANE{1'b0}};
            werr_r   <= 1'b0;
        end else begin
            werr_r <= 1'b0;
            case (wstate_r)
                W_IDLE: begin
                    if (s_wvalid) begin
                        wsize_r <= s_wsize;
                        waddr_r <= s_waddr[REG_AW-1:L];
                        wdata_r <= s_wdata;
                        wstrb_r <= s_wstrb;
                        wlast_r <= s_wlast;
                        if (wbad_s) begin
                            werr_r  <= 1'b1;
                            wmask_r <= {N_LANE{1'b0}};
                        end else if (wmask_in_s != {N_LANE{1'b0}}) begin
                            wmask_r  <= wmask_in_s;
                            wstate_r <= W_ISSUE;
                        end else begin
                            wmask_r <= {N_LANE{1'b0}};
                        end
                    end
                end
                W_ISSUE: begin
                    if (m_wready) begin
                        wmask_r <= wrest_s;
                        if (wrest_s == {N_LANE{1'b0}}) begin
                            wstate_r <= W_IDLE;
                        end
                    end
                end
                default: wstate_r <= W_IDLE;
            endcase
        end
    end

    assign s_wready = (wstate_r == W_IDLE) && !rst;
    assign s_werr   = werr_r;
    assign m_wvalid = (wstate_r == W_ISSUE);
    assign m_wsize  = reg_size(wsize_r);
    assign m_waddr  = (waddr_r & ~LANE_MASK) | WW'(wlane_s);
    assign m_wdata  = wdata_r[wlane_s*REG_DW +: REG_DW];
    assign m_wstrb  = wstrb_r[wlane_s*SB +: SB];
    assign m_wlast  = m_wvalid && wlast_r && (wrest_s == {N_LANE{1'b0}});

    // Lane count and aligned start lane of an incoming read request.
    always_comb begin
        rbad_s = int'(s_rsize) > SMAX;
        if (!rbad_s && int'(s_rsize) >= L) begin
            rn_s = 1 << (int'(s_rsize) - L);
        end else begin
            rn_s = 1;
        end
        rstart_s = s_raddr[L+MW-1:L] & MW'(N_LANE - 1) & ~MW'(rn_s - 1);
    end

    // Read FSM: request each lane in turn, merge data one cycle after each grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            rstate_r <= R_IDLE;
            rsize_r  <= {AXI_SW{1'b0}};
            raddr_r  <= {WW{1'b0}};
            rlane_r  <= {MW{1'b0}};
            rcnt_r   <= {(MW+1){1'b0}};
            acc_r    <= {AXI_DW{1'b0}};
            rerr_r   <= 1'b0;
        end else begin
            case (rstate_r)
                R_IDLE: begin
                    if (s_rvalid) begin
                        rsize_r <= s_rsize;
                        raddr_r <= s_raddr[REG_AW-1:L];
                        rlane_r <= rstart_s;
                        rcnt_r  <= (MW+1)'(rn_s);
                        acc_r   <= {AXI_DW{1'b0}};
                        rerr_r  <= rbad_s;
                        rstate_r <= rbad_s ? R_RESP : R_REQ;
                    end
                end
                R_REQ: begin
                    if (m_rready) begin
                        rstate_r <= R_WAIT;
                    end
                end
                R_WAIT: begin
                    acc_r[rlane_r*REG_DW +: REG_DW] <= m_rdata;
                    rerr_r <= rerr_r | m_rerr;
                    if (rcnt_r == (MW+1)'(1)) begin
                        rstate_r <= R_RESP;
                    end else begin
                        rlane_r  <= rlane_r + MW'(1);
                        rcnt_r   <= rcnt_r - (MW+1)'(1);
                        rstate_r <= R_REQ;
                    end
                end
                R_RESP: begin
                    if (s_rdready) begin
                        rstate_r <= R_IDLE;
                    end
                end
                default: rstate_r <= R_IDLE;
            endcase
        end
    end

    assign s_rready  = (rstate_r == R_IDLE) && !rst;
    assign s_rdvalid = (rstate_r == R_RESP);
    assign s_rdata   = acc_r;
    assign s_rslverr = rerr_r;
    assign m_rvalid  = (rstate_r == R_REQ);
    assign m_rsize   = reg_size(rsize_r);
    assign m_raddr   = (raddr_r & ~LANE_MASK) | WW'(rlane_r);

    // Address bits outside the register window are intentionally ignored.
    assign unused_s = ^{s_waddr, s_raddr};

endmodule

// File: tb/tb_asi_reg_bridge.sv
// Directed self-checking bench for asi_reg_bridge with default parameters (4 lanes of 32 bits).
module tb_asi_reg_bridge;
    logic         clk = 1'b0;
    logic         rst;
    logic [2:0]   s_wsize;
    logic [31:0]  s_waddr;
    logic [127:0] s_wdata;
    logic [15:0]  s_wstrb;
    logic         s_wlast, s_wvalid, s_wready, s_werr;
    logic [2:0]   m_wsize;
    logic [17:0]  m_waddr;
    logic [31:0]  m_wdata;
    logic [3:0]   m_wstrb;
    logic         m_wlast, m_wvalid, m_wready;
    logic [2:0]   s_rsize;
    logic [31:0]  s_raddr;
    logic         s_rvalid, s_rready;
    logic [127:0] s_rdata;
    logic         s_rslverr, s_rdvalid, s_rdready;
    logic [2:0]   m_rsize;
    logic [17:0]  m_raddr;
    logic         m_rvalid, m_rready;
    logic [31:0]  m_rdata;
    logic         m_rerr;

    int checks = 0;
    int errors = 0;
    logic [58:0]  wgot, wexp;
    logic [129:0] rgot, rexp;
    logic [213:0] outs;
    logic [127:0] wd;

    asi_reg_bridge dut (
        .clk(clk), .rst(rst),
        .s_wsize(s_wsize), .s_waddr(s_waddr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_wlast(s_wlast), .s_wvalid(s_wvalid), .s_wready(s_wready), .s_werr(s_werr),
        .m_wsize(m_wsize), .m_waddr(m_waddr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_wlast(m_wlast), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .s_rsize(s_rsize), .s_raddr(s_raddr), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .s_rdata(s_rdata), .s_rslverr(s_rslverr), .s_rdvalid(s_rdvalid), .s_rdready(s_rdready),
        .m_rsize(m_rsize), .m_raddr(m_raddr), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .m_rdata(m_rdata), .m_rerr(m_rerr)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic test_reset();
        rst = 1'b1;
        s_wsize = 3'd0; s_waddr = 32'h0; s_wdata = 128'h0; s_wstrb = 16'h0;
        s_wlast = 1'b0; s_wvalid = 1'b0; m_wready = 1'b0;
        s_rsize = 3'd0; s_raddr = 32'h0; s_rvalid = 1'b0; s_rdready = 1'b0;
        m_rready = 1'b0; m_rdata = 32'h0; m_rerr = 1'b0;
        repeat (2) @(negedge clk);
        outs = {s_wready, s_werr, m_wsize, m_waddr, m_wdata, m_wstrb, m_wlast, m_wvalid,
                s_rready, s_rdata, s_rslverr, s_rdvalid, m_rsize, m_raddr, m_rvalid};
        checks++;
        if (outs !== 214'h0) begin
            errors++;
            $display("FAIL reset_outputs got=%h want=0", outs);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({s_wready, s_rready} !== 2'b11) begin
            errors++;
            $display("FAIL reset_ready got=%b want=11", {s_wready, s_rready});
        end
    endtask

    task automatic test_full_write();
        wd = 128'hA0A0_0003_A0A0_0002_A0A0_0001_A0A0_0000;
        s_wsize = 3'd4; s_waddr = 32'h100; s_wdata = wd; s_wstrb = 16'hFFFF;
        s_wlast = 1'b1; s_wvalid = 1'b1; m_wready = 1'b1;
        checks++;
        if (s_wready !== 1'b1) begin
            errors++;
            $display("FAIL full_write_ready got=%b want=1", s_wready);
        end
        @(negedge clk);
        s_wvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wgot = {m_wvalid, m_wlast, m_wstrb, m_wsize, m_waddr, m_wdata};
            wexp = {1'b1, (i == 3), 4'hF, 3'd2, 18'(18'h40 + i), wd[i*32 +: 32]};
            checks++;
            if (wgot !== wexp || s_wready !== 1'b0) begin
                errors++;
                $display("FAIL full_write_lane%0d got=%h want=%h wready=%b", i, wgot, wexp, s_wready);
            end
            @(negedge clk);
        end
        checks++;
        if ({m_wvalid, s_wready} !== 2'b01) begin
            errors++;
            $display("FAIL full_write_done got=%b want=01", {m_wvalid, s_wready});
        end
    endtask

    task automatic test_sparse_write();
        wd = 128'h3333_3333_2222_2222_1111_1111_0000_0000;
        s_wsize = 3'd4; s_waddr = 32'h200; s_wdata = wd; s_wstrb = 16'h0F0F;
        s_wlast = 1'b0; s_wvalid = 1'b1; m_wready = 1'b0;
        @(negedge clk);
        s_wvalid = 1'b0;
        wexp = {1'b1, 1'b0, 4'hF, 3'd2, 18'h80, 32'h0000_0000};
        for (int i = 0; i < 4; i++) begin
            if (i == 3) m_wready = 1'b1;
            wgot = {m_wvalid, m_wlast, m_wstrb, m_wsize, m_waddr, m_wdata};
            checks++;
            if (wgot !== wexp) begin
                errors++;
                $display("FAIL sparse_hold%0d got=%h want=%h", i, wgot, wexp);
            end
            @(negedge clk);
        end
        wgot = {m_wvalid, m_wlast, m_wstrb, m_wsize, m_waddr, m_wdata};
        wexp = {1'b1, 1'b0, 4'hF, 3'd2, 18'h82, 32'h2222_2222};
        checks++;
        if (wgot !== wexp) begin
            errors++;
            $display("FAIL sparse_lane2 got=%h want=%h", wgot, wexp);
        end
        @(negedge clk);
        checks++;
        if ({m_wvalid, s_wready} !== 2'b01) begin
            errors++;
            $display("FAIL sparse_done got=%b want=01", {m_wvalid, s_wready});
        end
    endtask

    task automatic test_zero_mask();
        s_wsize = 3'd4; s_waddr = 32'h300; s_wstrb = 16'h0000; s_wlast = 1'b1; s_wvalid = 1'b1;
        @(negedge clk);
        s_wvalid = 1'b0;
        checks++;
        if ({m_wvalid, s_wready, s_werr} !== 3'b010) begin
            errors++;
            $display("FAIL zero_mask got=%b want=010", {m_wvalid, s_wready, s_werr});
        end
    endtask

    task automatic test_read_pair();
        logic [17:0] ea [2];
        logic [31:0] ed [2];
        int t;
        ea[0] = 18'h42; ea[1] = 18'h43;
        ed[0] = 32'hCAFE_0002; ed[1] = 32'hBEEF_0003;
        s_rsize = 3'd3; s_raddr = 32'h108; s_rvalid = 1'b1; s_rdready = 1'b0; m_rready = 1'b1;
        checks++;
        if (s_rready !== 1'b1) begin
            errors++;
            $display("FAIL read_pair_ready got=%b want=1", s_rready);
        end
        @(negedge clk);
        s_rvalid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            t = 0;
            while (m_rvalid !== 1'b1 && t < 20) begin
                @(negedge clk);
                t++;
            end
            checks++;
            if ({m_rvalid, m_raddr, m_rsize} !== {1'b1, ea[k], 3'd2}) begin
                errors++;
                $display("FAIL read_pair_req%0d got=%h want=%h", k, {m_rvalid, m_raddr, m_rsize}, {1'b1, ea[k], 3'd2});
            end
            @(negedge clk);
            m_rdata = ed[k]; m_rerr = 1'b0;
            @(negedge clk);
            m_rdata = 32'h0;
        end
        t = 0;
        while (s_rdvalid !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        rgot = {s_rdvalid, s_rslverr, s_rdata};
        rexp = {1'b1, 1'b0, 32'hBEEF_0003, 32'hCAFE_0002, 64'h0};
        checks++;
        if (rgot !== rexp) begin
            errors++;
            $display("FAIL read_pair_resp got=%h want=%h", rgot, rexp);
        end
        s_rdready = 1'b1;
        @(negedge clk);
        s_rdready = 1'b0;
        checks++;
        if ({s_rdvalid, s_rready} !== 2'b01) begin
            errors++;
            $display("FAIL read_pair_done got=%b want=01", {s_rdvalid, s_rready});
        end
    endtask

    task automatic test_read_err();
        int t;
        s_rsize = 3'd2; s_raddr = 32'h10C; s_rvalid = 1'b1; s_rdready = 1'b0; m_rready = 1'b1;
        @(negedge clk);
        s_rvalid = 1'b0;
        checks++;
        if ({m_rvalid, m_raddr, m_rsize} !== {1'b1, 18'h43, 3'd2}) begin
            errors++;
            $display("FAIL read_err_req got=%h want=%h", {m_rvalid, m_raddr, m_rsize}, {1'b1, 18'h43, 3'd2});
        end
        @(negedge clk);
        m_rdata = 32'h1234_5678; m_rerr = 1'b1;
        @(negedge clk);
        m_rdata = 32'h0; m_rerr = 1'b0;
        t = 0;
        while (s_rdvalid !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        rexp = {1'b1, 1'b1, 32'h1234_5678, 96'h0};
        for (int i = 0; i < 5; i++) begin
            rgot = {s_rdvalid, s_rslverr, s_rdata};
            checks++;
            if (rgot !== rexp) begin
                errors++;
                $display("FAIL read_err_hold%0d got=%h want=%h", i, rgot, rexp);
            end
            @(negedge clk);
        end
        s_rdready = 1'b1;
        @(negedge clk);
        s_rdready = 1'b0;
        checks++;
        if ({s_rdvalid, s_rready} !== 2'b01) begin
            errors++;
            $display("FAIL read_err_done got=%b want=01", {s_rdvalid, s_rready});
        end
    endtask

    task automatic test_illegal_size();
        s_wsize = 3'd5; s_waddr = 32'h100; s_wstrb = 16'hFFFF; s_wlast = 1'b1; s_wvalid = 1'b1;
        s_rsize = 3'd5; s_raddr = 32'h100; s_rvalid = 1'b1;
        @(negedge clk);
        s_wvalid = 1'b0; s_rvalid = 1'b0;
        rgot = {s_rdvalid, s_rslverr, s_rdata};
        checks++;
        if ({s_werr, m_wvalid, m_rvalid} !== 3'b100 || rgot !== {1'b1, 1'b1, 128'h0}) begin
            errors++;
            $display("FAIL illegal_size got=%b resp=%h want=100 resp=%h",
                     {s_werr, m_wvalid, m_rvalid}, rgot, {1'b1, 1'b1, 128'h0});
        end
        s_rdready = 1'b1;
        @(negedge clk);
        s_rdready = 1'b0;
        checks++;
        if ({s_werr, m_wvalid, s_rdvalid, s_wready, s_rready} !== 5'b00011) begin
            errors++;
            $display("FAIL illegal_after got=%b want=00011", {s_werr, m_wvalid, s_rdvalid, s_wready, s_rready});
        end
    endtask

    task automatic test_reset_midflight();
        s_wsize = 3'd4; s_waddr = 32'h100; s_wstrb = 16'hFFFF; s_wlast = 1'b1; s_wvalid = 1'b1;
        m_wready = 1'b0;
        s_rsize = 3'd4; s_raddr = 32'h0; s_rvalid = 1'b1; m_rready = 1'b1;
        @(negedge clk);
        s_wvalid = 1'b0; s_rvalid = 1'b0;
        @(negedge clk);
        checks++;
        if ({m_wvalid, m_rvalid, s_rdvalid} !== 3'b100) begin
            errors++;
            $display("FAIL midflight_state got=%b want=100", {m_wvalid, m_rvalid, s_rdvalid});
        end
        rst = 1'b1;
        @(negedge clk);
        outs = {s_wready, s_werr, m_wsize, m_waddr, m_wdata, m_wstrb, m_wlast, m_wvalid,
                s_rready, s_rdata, s_rslverr, s_rdvalid, m_rsize, m_raddr, m_rvalid};
        checks++;
        if (outs !== 214'h0) begin
            errors++;
            $display("FAIL midflight_reset got=%h want=0", outs);
        end
        rst = 1'b0; m_wready = 1'b1;
        @(negedge clk);
        checks++;
        if ({s_wready, s_rready, m_wvalid, m_rvalid} !== 4'b1100) begin
            errors++;
            $display("FAIL midflight_idle got=%b want=1100", {s_wready, s_rready, m_wvalid, m_rvalid});
        end
        wd = 128'h0;
        wd[63:32] = 32'hDEAD_BEE1;
        s_wsize = 3'd0; s_waddr = 32'h4; s_wdata = wd; s_wstrb = 16'h0010; s_wlast = 1'b1; s_wvalid = 1'b1;
        s_rsize = 3'd2; s_raddr = 32'h4; s_rvalid = 1'b1;
        @(negedge clk);
        s_wvalid = 1'b0; s_rvalid = 1'b0;
        wgot = {m_wvalid, m_wlast, m_wstrb, m_wsize, m_waddr, m_wdata};
        wexp = {1'b1, 1'b1, 4'h1, 3'd0, 18'h1, 32'hDEAD_BEE1};
        checks++;
        if (wgot !== wexp) begin
            errors++;
            $display("FAIL post_reset_write got=%h want=%h", wgot, wexp);
        end
        checks++;
        if ({m_rvalid, m_raddr, m_rsize} !== {1'b1, 18'h1, 3'd2}) begin
            errors++;
            $display("FAIL post_reset_rreq got=%h want=%h", {m_rvalid, m_raddr, m_rsize}, {1'b1, 18'h1, 3'd2});
        end
        @(negedge clk);
        m_rdata = 32'h5A5A_0001; m_rerr = 1'b0;
        checks++;
        if ({m_wvalid, s_wready} !== 2'b01) begin
            errors++;
            $display("FAIL post_reset_wdone got=%b want=01", {m_wvalid, s_wready});
        end
        @(negedge clk);
        m_rdata = 32'h0;
        rgot = {s_rdvalid, s_rslverr, s_rdata};
        rexp = {1'b1, 1'b0, 64'h0, 32'h5A5A_0001, 32'h0};
        checks++;
        if (rgot !== rexp) begin
            errors++;
            $display("FAIL post_reset_resp got=%h want=%h", rgot, rexp);
        end
        s_rdready = 1'b1;
        @(negedge clk);
        s_rdready = 1'b0;
        checks++;
        if ({s_rdvalid, s_rready} !== 2'b01) begin
            errors++;
            $display("FAIL post_reset_rdone got=%b want=01", {s_rdvalid, s_rready});
        end
    endtask

    initial begin
        test_reset();
        test_full_write();
        test_sparse_write();
        test_zero_mask();
        test_read_pair();
        test_read_err();
        test_illegal_size();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
